// File: rtl/norm_collector.sv
// norm_collector: receive side of the normalizer output stream.
// Two lanes (one per core) arrive per beat, element 0 first, COL beats per
// vector. Each value is saturated to W_OUT, assembled into a COL-wide vector,
// and pushed into a 2-entry valid/ready output buffer.
// Ports:
//   clk, reset               clock, synchronous active-high reset
//   norm_valid               beat valid (no backpressure)
//   psum_norm_1/2 [W_IN]     core-1 / core-2 element for this beat
//   flush                    drop the partially assembled vector
//   m_valid, m_ready         output handshake (head of buffer)
//   m_data_1/2 [COL*W_OUT]   assembled vectors, lane k at [k*W_OUT +: W_OUT]
//   vec_count [16]           accepted pushes, wrapping
//   overflow                 sticky: a completed vector was dropped

// Unsigned saturation from W_IN down to W_OUT bits (W_IN > W_OUT).
module norm_sat #(
  parameter int W_IN  = 16,
  parameter int W_OUT = 8
) (
  input  logic [W_IN-1:0]  in_val,
  output logic [W_OUT-1:0] out_val
);
  assign out_val = (|in_val[W_IN-1:W_OUT]) ? '1 : in_val[W_OUT-1:0];
endmodule

module norm_collector #(
  parameter int COL   = 8,
  parameter int W_IN  = 16,
  parameter int W_OUT = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 norm_valid,
  input  logic [W_IN-1:0]      psum_norm_1,
  input  logic [W_IN-1:0]      psum_norm_2,
  input  logic                 flush,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic [COL*W_OUT-1:0] m_data_1,
  output logic [COL*W_OUT-1:0] m_data_2,
  output logic [15:0]          vec_count,
  output logic                 overflow
);
  localparam int IDX_W = (COL > 1) ? $clog2(COL) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(COL-1);

  typedef struct packed {
    logic [COL-1:0][W_OUT-1:0] d1;
    logic [COL-1:0][W_OUT-1:0] d2;
  } vec_t;

  // ---- per-core saturation ----
  logic [1:0][W_IN-1:0]  beat_in;
  logic [1:0][W_OUT-1:0] beat_sat;
  assign beat_in = {psum_norm_2, psum_norm_1};

  genvar c;
  generate
    for (c = 0; c < 2; c++) begin : g_sat
      norm_sat #(.W_IN(W_IN), .W_OUT(W_OUT)) u_sat (
        .in_val (beat_in[c]),
        .out_val(beat_sat[c])
      );
    end
  endgenerate

  // ---- assembly ----
  logic [IDX_W-1:0] idx;
  vec_t             asm_q;
  vec_t             push_vec;
  logic             complete;

  assign complete = norm_valid & ~flush & (idx == LAST_IDX);

  // The final beat bypasses the assembly register straight into the push.
  always_comb begin
    push_vec = asm_q;
    push_vec.d1[COL-1] = beat_sat[0];
    push_vec.d2[COL-1] = beat_sat[1];
  end

  // Stale lanes after a flush need no clearing: every lane is rewritten
  // before the next completion.
  always_ff @(posedge clk) begin
    if (reset) begin
      idx   <= '0;
      asm_q <= '0;
    end else if (flush) begin
      idx <= '0;
    end else if (norm_valid) begin
      asm_q.d1[idx] <= beat_sat[0];
      asm_q.d2[idx] <= beat_sat[1];
      idx <= (idx == LAST_IDX) ? '0 : idx + 1'b1;
    end
  end

  // ---- 2-entry output buffer ----
  vec_t       mem [2];
  logic       wr_ptr, rd_ptr;
  logic [1:0] count;
  logic       pop, push, drop, full;

  // Outputs depend on registers only; m_ready affects only the next state.
  assign m_valid  = (count != 2'd0);
  assign m_data_1 = mem[rd_ptr].d1;
  assign m_data_2 = mem[rd_ptr].d2;

  assign full = (count == 2'd2);
  assign pop  = m_valid & m_ready;
  assign push = complete & (~full | pop);
  assign drop = complete & full & ~pop;

  // When full and popping, wr_ptr == rd_ptr: the new entry lands in the slot
  // being vacated, which becomes the tail once rd_ptr advances.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 2; i++) mem[i] <= '0;
      wr_ptr    <= 1'b0;
      rd_ptr    <= 1'b0;
      count     <= 2'd0;
      vec_count <= 16'd0;
      overflow  <= 1'b0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_vec;
        wr_ptr      <= ~wr_ptr;
        vec_count   <= vec_count + 16'd1;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
      if (drop) overflow <= 1'b1;
    end
  end
endmodule

// File: tb/tb_norm_collector.sv
// Directed bench for norm_collector (COL=8, W_IN=16, W_OUT=8): a table of
// single vectors with hand-computed saturated results, plus hand-written
// sequences for gaps, flush, overflow, full-with-pop and mid-vector reset.
module tb_norm_collector;
  logic        clk = 1'b0;
  logic        reset;
  logic        norm_valid;
  logic [15:0] psum_norm_1, psum_norm_2;
  logic        flush;
  logic        m_valid;
  logic        m_ready;
  logic [63:0] m_data_1, m_data_2;
  logic [15:0] vec_count;
  logic        overflow;

  norm_collector #(.COL(8), .W_IN(16), .W_OUT(8)) dut (
    .clk(clk), .reset(reset), .norm_valid(norm_valid),
    .psum_norm_1(psum_norm_1), .psum_norm_2(psum_norm_2), .flush(flush),
    .m_valid(m_valid), .m_ready(m_ready), .m_data_1(m_data_1),
    .m_data_2(m_data_2), .vec_count(vec_count), .overflow(overflow)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0][15:0] p1;
    logic [7:0][15:0] p2;
    logic [7:0][7:0]  e1;
    logic [7:0][7:0]  e2;
  } vec_t;

  vec_t tbl [3];
  int   checks = 0;
  int   errors = 0;
  int   exp_cnt;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp_v);
    end
  endtask

  function automatic logic [7:0][15:0] mk(input int base);
    logic [7:0][15:0] v;
    for (int k = 0; k < 8; k++) v[k] = 16'(base + k);
    return v;
  endfunction

  function automatic logic [7:0][7:0] ex(input int base);
    logic [7:0][7:0] v;
    for (int k = 0; k < 8; k++) v[k] = 8'(base + k);
    return v;
  endfunction

  task automatic beat(input logic [15:0] a, input logic [15:0] b);
    norm_valid  = 1'b1;
    psum_norm_1 = a;
    psum_norm_2 = b;
    tick();
    norm_valid  = 1'b0;
  endtask

  task automatic send_vec(input logic [7:0][15:0] a, input logic [7:0][15:0] b);
    for (int k = 0; k < 8; k++) beat(a[k], b[k]);
  endtask

  task automatic do_reset;
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    // lane k = k*10 / k+1
    tbl[0].p1 = {16'd70, 16'd60, 16'd50, 16'd40, 16'd30, 16'd20, 16'd10, 16'd0};
    tbl[0].p2 = {16'd8, 16'd7, 16'd6, 16'd5, 16'd4, 16'd3, 16'd2, 16'd1};
    tbl[0].e1 = {8'd70, 8'd60, 8'd50, 8'd40, 8'd30, 8'd20, 8'd10, 8'd0};
    tbl[0].e2 = {8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1};
    // saturation: 256 -> 255, 0x1234 -> 255, 0xFF stays
    tbl[1].p1 = {16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'h1234, 16'd256};
    tbl[1].p2 = {16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'h00FF};
    tbl[1].e1 = {48'd0, 8'hFF, 8'hFF};
    tbl[1].e2 = {56'd0, 8'hFF};
    // boundary mix around 255/256
    tbl[2].p1 = {8{16'hFFFF}};
    tbl[2].p2 = {16'h0100, 16'h00FE, 16'h8000, 16'h0001, 16'h01FF, 16'h00FF, 16'h0101, 16'h0000};
    tbl[2].e1 = {8{8'hFF}};
    tbl[2].e2 = {8'hFF, 8'hFE, 8'hFF, 8'h01, 8'hFF, 8'hFF, 8'hFF, 8'h00};

    reset = 1'b1; norm_valid = 1'b0; psum_norm_1 = '0; psum_norm_2 = '0;
    flush = 1'b0; m_ready = 1'b1;
    tick(); tick();
    reset = 1'b0;
    chk("rst_m_valid", 64'(m_valid), 64'd0);
    chk("rst_m_data_1", m_data_1, 64'd0);
    chk("rst_m_data_2", m_data_2, 64'd0);
    chk("rst_vec_count", 64'(vec_count), 64'd0);
    chk("rst_overflow", 64'(overflow), 64'd0);

    // ---- table: one vector each, m_ready=1 ----
    exp_cnt = 0;
    for (int i = 0; i < 3; i++) begin
      for (int k = 0; k < 8; k++) begin
        if (k == 7) chk("tbl_valid_before_last", 64'(m_valid), 64'd0);
        beat(tbl[i].p1[k], tbl[i].p2[k]);
      end
      exp_cnt++;
      chk("tbl_m_valid", 64'(m_valid), 64'd1);
      chk("tbl_m_data_1", m_data_1, tbl[i].e1);
      chk("tbl_m_data_2", m_data_2, tbl[i].e2);
      chk("tbl_vec_count", 64'(vec_count), 64'(exp_cnt));
      chk("tbl_overflow", 64'(overflow), 64'd0);
      tick();
      chk("tbl_popped", 64'(m_valid), 64'd0);
    end

    // ---- gaps: 3 beats, 5 idle, 5 beats ----
    for (int k = 0; k < 3; k++) beat(16'(100 + k), 16'(200 + k));
    for (int k = 0; k < 5; k++) tick();
    chk("gap_no_early_valid", 64'(m_valid), 64'd0);
    for (int k = 3; k < 8; k++) beat(16'(100 + k), 16'(200 + k));
    exp_cnt++;
    chk("gap_m_valid", 64'(m_valid), 64'd1);
    chk("gap_m_data_1", m_data_1, ex(100));
    chk("gap_m_data_2", m_data_2, ex(200));
    tick();

    // ---- flush mid-vector, then a full vector ----
    for (int k = 0; k < 4; k++) beat(16'h0050, 16'h0051);
    flush = 1'b1; tick(); flush = 1'b0;
    send_vec(mk(30), mk(60));
    exp_cnt++;
    chk("flush_m_data_1", m_data_1, ex(30));
    chk("flush_m_data_2", m_data_2, ex(60));
    chk("flush_vec_count", 64'(vec_count), 64'(exp_cnt));
    tick();

    // ---- flush on completion cycle: no push ----
    for (int k = 0; k < 7; k++) beat(16'h0011, 16'h0022);
    flush = 1'b1; beat(16'h0011, 16'h0022); flush = 1'b0;
    chk("flush_last_no_valid", 64'(m_valid), 64'd0);
    chk("flush_last_vec_count", 64'(vec_count), 64'(exp_cnt));
    send_vec(mk(5), mk(9));
    exp_cnt++;
    chk("after_flush_m_data_1", m_data_1, ex(5));
    tick();

    // ---- overflow: V0,V1,V2 back-to-back with m_ready=0 ----
    do_reset();
    m_ready = 1'b0;
    send_vec(mk(10), mk(110));
    send_vec(mk(20), mk(120));
    send_vec(mk(40), mk(140));
    chk("ovf_m_valid", 64'(m_valid), 64'd1);
    chk("ovf_hold_v0", m_data_1, ex(10));
    chk("ovf_flag", 64'(overflow), 64'd1);
    chk("ovf_vec_count", 64'(vec_count), 64'd2);
    tick();
    chk("ovf_stable_v0", m_data_2, ex(110));
    m_ready = 1'b1;
    tick();
    chk("ovf_head_v1", m_data_1, ex(20));
    chk("ovf_head_v1_valid", 64'(m_valid), 64'd1);
    tick();
    chk("ovf_drained", 64'(m_valid), 64'd0);
    chk("ovf_sticky", 64'(overflow), 64'd1);

    // ---- full with simultaneous pop ----
    do_reset();
    m_ready = 1'b0;
    send_vec(mk(10), mk(110));
    send_vec(mk(20), mk(120));
    for (int k = 0; k < 7; k++) beat(16'(40 + k), 16'(140 + k));
    m_ready = 1'b1;
    beat(16'd47, 16'd147);
    chk("fpop_overflow", 64'(overflow), 64'd0);
    chk("fpop_vec_count", 64'(vec_count), 64'd3);
    chk("fpop_head_v1", m_data_1, ex(20));
    tick();
    chk("fpop_head_v2_1", m_data_1, ex(40));
    chk("fpop_head_v2_2", m_data_2, ex(140));
    tick();
    chk("fpop_drained", 64'(m_valid), 64'd0);

    // ---- reset mid-vector with one vector buffered ----
    do_reset();
    m_ready = 1'b0;
    send_vec(mk(10), mk(110));
    for (int k = 0; k < 5; k++) beat(16'(70 + k), 16'(170 + k));
    reset = 1'b1; norm_valid = 1'b1; psum_norm_1 = 16'd99; psum_norm_2 = 16'd99;
    tick();
    reset = 1'b0; norm_valid = 1'b0;
    chk("mrst_m_valid", 64'(m_valid), 64'd0);
    chk("mrst_vec_count", 64'(vec_count), 64'd0);
    chk("mrst_overflow", 64'(overflow), 64'd0);
    chk("mrst_m_data_1", m_data_1, 64'd0);
    m_ready = 1'b1;
    send_vec(mk(150), mk(50));
    chk("mrst_new_valid", 64'(m_valid), 64'd1);
    chk("mrst_new_data_1", m_data_1, ex(150));
    chk("mrst_new_data_2", m_data_2, ex(50));
    chk("mrst_new_count", 64'(vec_count), 64'd1);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/norm_collector.md
Name: norm_collector

Overview:
- Receiving end of the normalizer output stream.
- Captures the serialized normalized values from both cores (two lanes per beat, element 0 first, COL beats per vector).
- Saturates each value to W_OUT and reassembles COL-wide vectors.
- Presents the vectors to the downstream writeback through a 2-entry valid/ready output buffer, with overflow detection.

Parameters:
- COL, 8, elements per vector (beats per frame); power of two.
- W_IN, 16, width of each incoming normalized value (unsigned).
- W_OUT, 8, width of each stored output element (unsigned, saturated).

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous, active-high reset.
- norm_valid  input  1  beat valid. No backpressure: a beat is accepted whenever norm_valid=1.
- psum_norm_1  input  W_IN  core-1 normalized element for the current beat.
- psum_norm_2  input  W_IN  core-2 normalized element for the current beat.
- flush  input  1  discards the partially assembled vector.
- m_valid  output  1  head of the output buffer is valid.
- m_ready  input  1  downstream accepts the head entry.
- m_data_1  output  COL*W_OUT  core-1 vector; lane k at bits [k*W_OUT +: W_OUT].
- m_data_2  output  COL*W_OUT  core-2 vector, same packing.
- vec_count  output  16  number of vectors pushed into the buffer; wraps at 2^16.
- overflow  output  1  sticky flag: a completed vector was dropped.

Behaviour:
- Reset: clears beat index, buffer pointers/occupancy, vec_count and overflow.
  - After reset: m_valid=0, m_data_1=m_data_2=0, vec_count=0, overflow=0.
  - Reset has priority over every other input, including reset mid-vector or while the buffer is full.
- Saturation (per element): out = (in > 2^W_OUT-1) ? 2^W_OUT-1 : in[W_OUT-1:0].
  - Example, W_OUT=8: 256 becomes 255; 255 stays 255; 0 stays 0.
- Assembly:
  - Beat index idx counts 0..COL-1.
  - On each cycle with norm_valid=1, sat(psum_norm_1) is written to assembly lane idx for core 1, and sat(psum_norm_2) to lane idx for core 2.
  - Gaps (norm_valid=0) hold idx and the partial contents.
  - When idx==COL-1 and norm_valid=1, the vector is complete and idx wraps to 0.
- Completion cycle: the completed vector, including the last beat's values, is pushed into the output buffer.
  - Datapath must bypass the last beat directly into the push, so no extra beat of buffering is needed.
- Output buffer: 2-entry FIFO, head-presented.
  - Pop occurs when m_valid & m_ready.
  - Push on cycle t makes data visible at m_valid/m_data on cycle t+1 if the buffer was empty.
  - Latency from final beat to m_valid = 1 cycle.
- Push while full:
  - If a pop occurs in the same cycle, the push is accepted.
  - Otherwise the vector is dropped, overflow is set (sticky until reset) and vec_count does not increment.
- Push while empty with m_ready=1 in the same cycle: no pop happens, since m_valid was 0.
- vec_count increments by 1 on every accepted push; 0xFFFF wraps to 0.
- m_data is stable while m_valid=1 and m_ready=0. m_valid never deasserts without a pop.
- flush=1: idx is reset to 0 and partial contents are discarded; the output buffer is untouched.
  - flush together with norm_valid: flush wins and the beat is discarded.
  - flush on a completion cycle: no push occurs.
- Implementation: no combinational path from m_ready to m_valid or m_data. The buffer occupancy decision may use m_ready combinationally.

Test Plan:
- Single vector, COL=8: beats with psum_norm_1=k*10 and psum_norm_2=k+1 for k=0..7, contiguous, m_ready=1.
  -> m_valid high exactly 1 cycle after beat 7, lane k = k*10 and k+1; vec_count=1; overflow=0.
- Saturation: beat 0 with psum_norm_1=256, psum_norm_2=0x00FF; beat 1 with psum_norm_1=0x1234; remaining beats 0.
  -> m_data_1 lane0=255, lane1=255; m_data_2 lane0=255.
- Gaps and flush:
  - Send 3 beats, then 5 idle cycles, then 5 beats -> one vector with correct lanes.
  - Send 4 beats, pulse flush, then 8 beats -> only the 8-beat vector appears; vec_count=1.
- Backpressure/overflow: m_ready=0, send 3 back-to-back vectors V0, V1, V2.
  -> m_valid=1 holding V0; V2 dropped; overflow=1; vec_count=2.
  - Then raise m_ready -> V0, V1 delivered in order; m_valid=0; overflow remains 1.
- Full with simultaneous pop: buffer holds 2, m_ready=1 on V2's completion cycle.
  -> V2 accepted; overflow=0; delivered order V0, V1, V2; vec_count=3.
- Reset mid-operation: reset after 5 beats with 1 vector buffered.
  -> next cycle m_valid=0, vec_count=0, overflow=0; a following 8-beat vector is captured with lane 0 = first post-reset beat.
